// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between instruction fetch and data access.
// Define MEMORY_ARBITER_LLSC_EN to enable the LL/SC link register.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_rdy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_starve_cnt;
    logic w_dreq, w_sat, w_forced, w_sc_ok, w_sc_fail;
    assign w_dreq = dREN | dWEN;
    assign w_sat = r_starve_cnt == CW'(STARVE_MAX);
    // Forcing only applies while a fetch is actually waiting, so data never deadlocks.
    assign w_forced = w_sat & iREN;
`ifdef MEMORY_ARBITER_LLSC_EN
    logic              r_link_valid;
    logic [ADDR_W-1:0] r_link_addr;
    logic w_link_hit, w_ll_done, w_clr;
    assign w_link_hit = r_link_valid && r_link_addr == daddr;
    assign w_sc_ok = dWEN & datomic & w_link_hit;
    assign w_sc_fail = dWEN & datomic & !w_link_hit;
    assign w_ll_done = r_state == DATA && dREN && !dWEN && datomic && ram_rdy;
    assign w_clr = (r_state == DATA && dWEN &&
                    (datomic ? (ram_rdy || !w_link_hit) : (ram_rdy && daddr == r_link_addr)))
                || (snoop_inv && snoop_addr == r_link_addr);
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (w_ll_done) begin
            r_link_valid <= !(snoop_inv && snoop_addr == daddr);
            r_link_addr  <= daddr;
        end else if (w_clr) begin
            r_link_valid <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{datomic, snoop_inv, snoop_addr};
    assign w_sc_ok = 1'b0;
    assign w_sc_fail = 1'b0;
`endif
    always_comb begin
        w_next   = r_state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = daddr;
        ramstore = dstore;
        iload    = ramload;
        dload    = ramload;
        iwait    = iREN;
        dwait    = w_dreq;
        case (r_state)
            IDLE: w_next = (w_dreq && !w_forced) ? DATA : iREN ? INSTR : IDLE;
            DATA: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (w_sc_fail) begin
                    dwait  = 1'b0;
                    dload  = '0;
                    w_next = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = !dWEN;
                    dwait  = !ram_rdy;
                    dload  = w_sc_ok ? DATA_W'(1) : ramload;
                    w_next = ram_rdy ? IDLE : DATA;
                end
            end
            INSTR: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    iwait   = !ram_rdy;
                    w_next  = ram_rdy ? IDLE : INSTR;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == DATA)
                r_starve_cnt <= !iREN ? '0 : w_sat ? r_starve_cnt : r_starve_cnt + CW'(1);
            else if (r_state == IDLE && w_next == INSTR)
                r_starve_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of grant order, stalls, aborts, reset and LL/SC.
module tb_memory_arbiter;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        iREN = 0, dREN = 0, dWEN = 0, datomic = 0, snoop_inv = 0, ram_rdy = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, snoop_addr = 0, ramload = 0;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int          n_tests = 0, n_fail = 0;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_rdy(ram_rdy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    initial begin
        logic [9:0] exp_pat;
        logic [15:0] got;
        int ng;
        // reset with requests pending
        nxt;
        iREN = 1; dREN = 1;
        smp;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_starve", dut.r_starve_cnt, 0);
        nxt;
        nRST = 1; iREN = 0; dREN = 0;
        // single instruction fetch
        nxt;
        iREN = 1; iaddr = 32'h0; ram_rdy = 1; ramload = 32'h1234;
        smp;
        chk("fetch_idle_ramREN", ramREN, 0);
        chk("fetch_idle_iwait", iwait, 1);
        nxt;
        smp;
        chk("fetch_ramREN", ramREN, 1);
        chk("fetch_ramaddr", ramaddr, 32'h0);
        chk("fetch_iwait", iwait, 0);
        chk("fetch_iload", iload, 32'h1234);
        nxt;
        smp;
        chk("fetch_back_idle", ramREN, 0);
        nxt;
        iREN = 0;
        nxt;
        // starvation: both ports hammer the RAM
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ram_rdy = 1;
        exp_pat = 10'b10_0001_0000;
        ng = 0; got = '0;
        for (int k = 0; k < 20; k++) begin
            smp;
            if (ramREN && ng < 16) begin
                got[ng] = (ramaddr == 32'h200);
                if (ramaddr == 32'h100) chk("starve_iwait", iwait, 1);
                ng++;
            end
        end
        chk("grant_count", ng, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("grant%0d", i), got[i], exp_pat[i]);
        nxt;
        iREN = 0; dREN = 0; ram_rdy = 0;
        // write with 3-cycle RAM delay; read+write counts as write
        nxt;
        dWEN = 1; dREN = 1; daddr = 32'h40; dstore = 32'hDEADBEEF;
        smp;
        chk("wr_idle_dwait", dwait, 1);
        chk("wr_idle_ramWEN", ramWEN, 0);
        for (int k = 0; k < 3; k++) begin
            nxt;
            smp;
            chk("wr_ramWEN", ramWEN, 1);
            chk("wr_ramREN", ramREN, 0);
            chk("wr_ramstore", ramstore, 32'hDEADBEEF);
            chk("wr_ramaddr", ramaddr, 32'h40);
            chk("wr_dwait", dwait, 1);
        end
        nxt;
        ram_rdy = 1;
        smp;
        chk("wr_done_dwait", dwait, 0);
        chk("wr_done_ramWEN", ramWEN, 1);
        nxt;
        dWEN = 0; dREN = 0; ram_rdy = 0;
        smp;
        chk("wr_after_ramWEN", ramWEN, 0);
        // abort: data request drops mid-access
        nxt;
        dREN = 1; daddr = 32'h10;
        nxt;
        smp;
        chk("abort_ramREN_on", ramREN, 1);
        dREN = 0;
        #1;
        chk("abort_ramREN_off", ramREN, 0);
        nxt;
        iREN = 1; iaddr = 32'h300; ram_rdy = 1;
        smp;
        chk("abort_idle", ramREN, 0);
        nxt;
        smp;
        chk("abort_fetch_ramREN", ramREN, 1);
        chk("abort_fetch_addr", ramaddr, 32'h300);
        nxt;
        iREN = 0; ram_rdy = 0;
        // reset during a data access
        nxt;
        dREN = 1; iREN = 1; daddr = 32'h20;
        nxt;
        smp;
        chk("mid_ramREN", ramREN, 1);
        chk("mid_starve", dut.r_starve_cnt, 1);
        nRST = 0;
        nxt;
        nRST = 1; iREN = 0;
        smp;
        chk("mid_rst_ramREN", ramREN, 0);
        chk("mid_rst_dwait", dwait, 1);
        chk("mid_rst_starve", dut.r_starve_cnt, 0);
        nxt;
        dREN = 0;
        nxt;
`ifdef MEMORY_ARBITER_LLSC_EN
        // LL then matching SC succeeds
        dREN = 1; datomic = 1; daddr = 32'h80; ram_rdy = 1; ramload = 32'h99;
        nxt;
        smp;
        chk("ll_dwait", dwait, 0);
        chk("ll_ramREN", ramREN, 1);
        nxt;
        dREN = 0; dWEN = 1; dstore = 32'h7;
        nxt;
        smp;
        chk("sc_ok_ramWEN", ramWEN, 1);
        chk("sc_ok_ramstore", ramstore, 32'h7);
        chk("sc_ok_dload", dload, 1);
        chk("sc_ok_dwait", dwait, 0);
        nxt;
        nxt;
        smp;
        chk("sc_again_ramWEN", ramWEN, 0);
        chk("sc_again_dwait", dwait, 0);
        chk("sc_again_dload", dload, 0);
        nxt;
        // LL then snoop invalidate breaks the link
        dWEN = 0; dREN = 1;
        nxt;
        smp;
        chk("ll2_dwait", dwait, 0);
        nxt;
        dREN = 0; dWEN = 1; snoop_inv = 1; snoop_addr = 32'h80;
        nxt;
        snoop_inv = 0;
        smp;
        chk("sc_snoop_ramWEN", ramWEN, 0);
        chk("sc_snoop_dwait", dwait, 0);
        chk("sc_snoop_dload", dload, 0);
        nxt;
        dWEN = 0; datomic = 0; ram_rdy = 0;
`else
        // without the link register SC is a plain write
        dWEN = 1; datomic = 1; daddr = 32'h80; dstore = 32'h7; ram_rdy = 1; ramload = 32'h55;
        nxt;
        smp;
        chk("sc_plain_ramWEN", ramWEN, 1);
        chk("sc_plain_ramstore", ramstore, 32'h7);
        chk("sc_plain_dload", dload, 32'h55);
        chk("sc_plain_dwait", dwait, 0);
        nxt;
        dWEN = 0; datomic = 0; ram_rdy = 0;
`endif
        nxt;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
